// File: rtl/keypad_pkg.sv
// Shared types and sizes for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int unsigned KP_ROWS = 4;
    localparam int unsigned KP_COLS = 4;
    localparam int unsigned KP_KEYS = 16;
    localparam int unsigned KEY_W   = 4;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_DEB,
        ST_PRESSED,
        ST_REL_DEB
    } kp_state_e;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_SINGLE,
        CLS_MULTI
    } scan_cls_e;

    function automatic logic [2:0] pop4(input logic [3:0] v);
        pop4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Matrix-side and key-event signals of the keypad scanner.
interface keypad_scan_if;
    import keypad_pkg::*;

    logic [KP_ROWS-1:0] row;
    logic [KP_COLS-1:0] col;
    logic [KP_KEYS-1:0] onehot;
    logic               key_valid;
    logic               key_down;

    // slave = scanner, master = matrix/consumer side
    modport slave  (input  row, output col, output onehot, output key_valid, output key_down);
    modport master (output row, input  col, input  onehot, input  key_valid, input  key_down);

endinterface

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the asynchronous, pulled-up row sense lines.
module keypad_sync
    import keypad_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [KP_ROWS-1:0] d_i,
    output logic [KP_ROWS-1:0] q_o
);

    logic [KP_ROWS-1:0] meta_q;
    logic [KP_ROWS-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad column scanner with per-scan classification and debounced
// press/release tracking; reports the accepted key as a held one-hot code.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned DEB_SCANS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    keypad_scan_if.slave  kp
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [KP_ROWS-1:0] row_sync;
    logic [DIV_W-1:0]   div_q;
    logic [1:0]         col_idx_q;
    logic [KP_COLS-1:0] col_q;
    logic [1:0]         acc_cnt_q;
    logic [KEY_W-1:0]   acc_key_q;

    kp_state_e          state_q, state_d;
    logic [KEY_W-1:0]   cand_q, cand_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [KP_KEYS-1:0] onehot_q, onehot_d;
    logic               key_valid_q, key_valid_d;
    logic               key_down_q, key_down_d;

    logic               sample_c;
    logic               end_scan_c;
    logic [KP_ROWS-1:0] row_low_c;
    logic [2:0]         row_pop_c;
    logic [1:0]         row_idx_c;
    logic [2:0]         tot_c;
    logic [KEY_W-1:0]   key_c;
    scan_cls_e          cls_c;
    logic [CNT_W-1:0]   cnt_nxt_c;
    logic               deb_done_c;

    keypad_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (kp.row),
        .q_o   (row_sync)
    );

    assign sample_c   = (div_q == DIV_W'(SCAN_DIV - 1));
    assign end_scan_c = sample_c && (col_idx_q == 2'd3);

    // Column timing: divider wraps straight into the next column, no gap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q     <= '0;
            col_idx_q <= '0;
            col_q     <= 4'b1110;
        end else if (sample_c) begin
            div_q     <= '0;
            col_idx_q <= col_idx_q + 2'd1;
            col_q     <= {col_q[KP_COLS-2:0], col_q[KP_COLS-1]};
        end else begin
            div_q     <= div_q + DIV_W'(1);
        end
    end

    // Per-column view of the synchronized rows, merged with earlier columns.
    always_comb begin
        row_low_c = ~row_sync;
        row_pop_c = pop4(row_low_c);
        row_idx_c = '0;
        for (int r = KP_ROWS - 1; r >= 0; r--) begin
            if (row_low_c[r]) row_idx_c = 2'(r);
        end
        tot_c = 3'(acc_cnt_q) + row_pop_c;
        key_c = (acc_cnt_q != 2'd0) ? acc_key_q : {col_idx_q, row_idx_c};
        if (tot_c == 3'd0)      cls_c = CLS_NONE;
        else if (tot_c == 3'd1) cls_c = CLS_SINGLE;
        else                    cls_c = CLS_MULTI;
    end

    // Low-row tally for the scan in progress; saturates at two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_cnt_q <= '0;
            acc_key_q <= '0;
        end else if (end_scan_c) begin
            acc_cnt_q <= '0;
            acc_key_q <= '0;
        end else if (sample_c) begin
            acc_cnt_q <= (tot_c >= 3'd2) ? 2'd2 : 2'(tot_c);
            acc_key_q <= key_c;
        end
    end

    assign cnt_nxt_c  = cnt_q + CNT_W'(1);
    assign deb_done_c = (cnt_nxt_c == CNT_W'(DEB_SCANS));

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Debounce transitions, evaluated only on the end-of-scan sample.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        if (end_scan_c) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cls_c == CLS_SINGLE) begin
                        cand_d  = key_c;
                        cnt_d   = CNT_W'(1);
                        state_d = ST_PRESS_DEB;
                    end
                end
                ST_PRESS_DEB: begin
                    if (cls_c == CLS_SINGLE) begin
                        if (key_c == cand_q) begin
                            cnt_d = cnt_nxt_c;
                            if (deb_done_c) state_d = ST_PRESSED;
                        end else begin
                            cand_d = key_c;
                            cnt_d  = CNT_W'(1);
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
                ST_PRESSED: begin
                    if (cls_c == CLS_NONE) begin
                        cnt_d   = CNT_W'(1);
                        state_d = ST_REL_DEB;
                    end
                end
                ST_REL_DEB: begin
                    if (cls_c == CLS_NONE) begin
                        cnt_d = cnt_nxt_c;
                        if (deb_done_c) state_d = ST_IDLE;
                    end else begin
                        state_d = ST_PRESSED;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output decisions; onehot holds until the next accepted key.
    always_comb begin
        onehot_d    = onehot_q;
        key_valid_d = 1'b0;
        key_down_d  = key_down_q;
        if (end_scan_c) begin
            if (state_q == ST_PRESS_DEB && cls_c == CLS_SINGLE &&
                key_c == cand_q && deb_done_c) begin
                onehot_d    = KP_KEYS'(1) << cand_q;
                key_valid_d = 1'b1;
                key_down_d  = 1'b1;
            end else if (state_q == ST_REL_DEB && cls_c == CLS_NONE && deb_done_c) begin
                key_down_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cand_q      <= '0;
            cnt_q       <= '0;
            onehot_q    <= '0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            onehot_q    <= onehot_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
        end
    end

    assign kp.col       = col_q;
    assign kp.onehot    = onehot_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_down  = key_down_q;

endmodule
